// File: rtl/membus_dma_pkg.sv
// Shared types and constants for the memory-to-memory DMA: FSM encoding,
// config register offsets and the byte-strobe merge helper.
package membus_dma_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StFin
    } dma_state_e;

    // Word offsets decoded from addr[3:2]
    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam logic [31:0] WORD_STEP = 32'd4;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/membus_dma_regs.sv
// Config responder: one-cycle-latency handshake, address decode, byte-strobe
// merge and registered read mux. Register storage lives in the parent.
module membus_dma_regs
    import membus_dma_pkg::*;
#(
    parameter int unsigned LEN_BITS = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [3:0]          wstrb_i,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         wdata_i,
    output logic [31:0]         rdata_o,
    input  logic [31:0]         src_i,
    input  logic [31:0]         dst_i,
    input  logic [LEN_BITS-1:0] len_i,
    input  logic [2:0]          ctrl_i,
    output logic                src_we_o,
    output logic                dst_we_o,
    output logic                len_we_o,
    output logic                ctrl_we_o,
    output logic [31:0]         wr_data_o,
    output logic [2:0]          ctrl_data_o
);

    logic        valid_q;
    logic        ready_q;
    logic [31:0] rdata_q;
    logic        accept;
    logic        wr;
    logic [1:0]  sel;
    logic [31:0] cur;
    logic [31:0] rd_mux;
    logic [31:0] merged;
    logic        unused_addr;

    assign sel         = addr_i[3:2];
    assign unused_addr = ^{addr_i[31:4], addr_i[1:0]};

    // A request is taken on the rising edge of valid; ready answers next cycle.
    assign accept = valid_i && !valid_q && !ready_q;
    assign wr     = accept && (|wstrb_i);

    always_comb begin
        cur    = '0;
        rd_mux = '0;
        unique case (sel)
            REG_SRC: begin
                cur    = src_i;
                rd_mux = src_i;
            end
            REG_DST: begin
                cur    = dst_i;
                rd_mux = dst_i;
            end
            REG_LEN: begin
                cur    = 32'(len_i);
                rd_mux = 32'(len_i);
            end
            REG_CTRL: begin
                cur    = '0;
                rd_mux = {29'b0, ctrl_i};
            end
            default: begin
                cur    = '0;
                rd_mux = '0;
            end
        endcase
    end

    always_comb begin
        merged    = apply_wstrb(cur, wdata_i, wstrb_i);
        wr_data_o = merged;
        // Addresses are word aligned
        if (sel == REG_SRC || sel == REG_DST) wr_data_o[1:0] = 2'b00;
    end

    assign src_we_o    = wr && (sel == REG_SRC);
    assign dst_we_o    = wr && (sel == REG_DST);
    assign len_we_o    = wr && (sel == REG_LEN);
    assign ctrl_we_o   = accept && wstrb_i[0] && (sel == REG_CTRL);
    assign ctrl_data_o = wdata_i[2:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            valid_q <= valid_i;
            ready_q <= accept;
            rdata_q <= accept ? rd_mux : '0;
        end
    end

    assign ready_o = ready_q;
    assign rdata_o = rdata_q;

endmodule

// File: rtl/membus_dma.sv
// Word-copy DMA: reads LEN words from SRC and writes them to DST over a
// valid/ready bus, one outstanding transaction with an idle cycle between.
module membus_dma
    import membus_dma_pkg::*;
#(
    parameter int unsigned LEN_BITS = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    output logic        ready,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [31:0] m_rdata,
    output logic        irq
);

    dma_state_e          state_q, state_d;
    logic [31:0]         src_q, src_d;
    logic [31:0]         dst_q, dst_d;
    logic [31:0]         buf_q, buf_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic                done_q, done_d;
    logic                ie_q, ie_d;
    logic                gap_q, gap_d;

    logic                busy;
    logic                xfer;
    logic                start;
    logic                src_we, dst_we, len_we, ctrl_we;
    logic [31:0]         wr_data;
    logic [2:0]          ctrl_data;

    membus_dma_regs #(
        .LEN_BITS(LEN_BITS)
    ) u_regs (
        .clk_i      (clk),
        .rst_ni     (resetn),
        .valid_i    (valid),
        .ready_o    (ready),
        .wstrb_i    (wstrb),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .rdata_o    (rdata),
        .src_i      (src_q),
        .dst_i      (dst_q),
        .len_i      (len_q),
        .ctrl_i     ({ie_q, done_q, busy}),
        .src_we_o   (src_we),
        .dst_we_o   (dst_we),
        .len_we_o   (len_we),
        .ctrl_we_o  (ctrl_we),
        .wr_data_o  (wr_data),
        .ctrl_data_o(ctrl_data)
    );

    assign busy  = (state_q != StIdle);
    assign start = ctrl_we && ctrl_data[0] && !busy;

    // gap_q holds m_valid low for the cycle after each accepted transaction
    assign m_valid = ((state_q == StRd) || (state_q == StWr)) && !gap_q;
    assign xfer    = m_valid && m_ready;

    always_comb begin
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        if (m_valid) begin
            if (state_q == StRd) begin
                m_addr = src_q;
            end else begin
                m_addr  = dst_q;
                m_wdata = buf_q;
                m_wstrb = 4'hF;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        buf_d   = buf_q;
        len_d   = len_q;
        done_d  = done_q;
        ie_d    = ie_q;
        gap_d   = xfer;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = (len_q == '0) ? StFin : StRd;
            end
            StRd: begin
                if (xfer) begin
                    buf_d   = m_rdata;
                    state_d = StWr;
                end
            end
            StWr: begin
                if (xfer) begin
                    src_d   = src_q + WORD_STEP;
                    dst_d   = dst_q + WORD_STEP;
                    len_d   = len_q - LEN_BITS'(1);
                    state_d = (len_q != LEN_BITS'(1)) ? StRd : StFin;
                end
            end
            StFin: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (!busy) begin
            if (src_we) src_d = wr_data;
            if (dst_we) dst_d = wr_data;
            if (len_we) len_d = wr_data[LEN_BITS-1:0];
        end

        if (ctrl_we) begin
            ie_d = ctrl_data[2];
            if (ctrl_data[1]) done_d = 1'b0;
        end
        if (start) done_d = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            buf_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            ie_q    <= 1'b0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            buf_q   <= buf_d;
            len_q   <= len_d;
            done_q  <= done_d;
            ie_q    <= ie_d;
            gap_q   <= gap_d;
        end
    end

    assign irq = done_q && ie_q;

endmodule

// File: tb/tb_membus_dma.sv
// Self-checking bench for membus_dma: scoreboard of expected bus transactions
// checked by a memory model with random m_ready stalls.
module tb_membus_dma;

    localparam logic [31:0] A_SRC  = 32'h0;
    localparam logic [31:0] A_DST  = 32'h4;
    localparam logic [31:0] A_LEN  = 32'h8;
    localparam logic [31:0] A_CTRL = 32'hC;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [3:0]  wstrb = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata = '0;
    logic        irq;

    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] mem[logic [31:0]];

    int          max_stall = 0;
    int          stall_left = 0;
    bit          armed = 1'b0;
    bit          moved = 1'b0;
    int          valid_cycles = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;

    membus_dma #(
        .LEN_BITS(16)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .valid  (valid),
        .ready  (ready),
        .wstrb  (wstrb),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_wstrb(m_wstrb),
        .m_rdata(m_rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5a5a_1234;
    endfunction

    task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        txn_t t;
        for (int i = 0; i < n; i++) begin
            t.a = s + 32'(4 * i);
            t.d = '0;
            t.s = 4'h0;
            exp_q.push_back(t);
            t.a = d + 32'(4 * i);
            t.d = mem_rd(s + 32'(4 * i));
            t.s = 4'hF;
            exp_q.push_back(t);
        end
    endtask

    // Memory model: drives m_ready/m_rdata on the falling edge so the DUT
    // samples them on the following rising edge.
    always @(negedge clk or negedge resetn) begin
        txn_t t;
        if (!resetn) begin
            m_ready = 1'b0;
            armed   = 1'b0;
            exp_q.delete();
        end else begin
            if (m_valid) valid_cycles++;
            if (m_ready) begin
                m_ready = 1'b0;
                armed   = 1'b0;
                check_eq("valid_drop", {31'b0, m_valid}, 32'd0);
            end else if (m_valid) begin
                if (!armed) begin
                    armed      = 1'b1;
                    stall_left = $urandom_range(max_stall, 0);
                    cap_addr   = m_addr;
                    cap_wdata  = m_wdata;
                    cap_wstrb  = m_wstrb;
                    moved      = 1'b0;
                end else if (m_addr !== cap_addr || m_wdata !== cap_wdata ||
                             m_wstrb !== cap_wstrb) begin
                    moved = 1'b1;
                end
                if (stall_left == 0) begin
                    check_eq("bus_stable", {31'b0, moved}, 32'd0);
                    check_eq("txn_pending", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        t = exp_q.pop_front();
                        check_eq("bus_addr", m_addr, t.a);
                        check_eq("bus_wstrb", {28'b0, m_wstrb}, {28'b0, t.s});
                        if (t.s == 4'hF) check_eq("bus_wdata", m_wdata, t.d);
                    end
                    if (m_wstrb == 4'hF) mem[m_addr] = m_wdata;
                    else m_rdata = mem_rd(m_addr);
                    m_ready = 1'b1;
                end else begin
                    stall_left--;
                end
            end else if (armed) begin
                check_eq("valid_held", {31'b0, m_valid}, 32'd1);
                armed = 1'b0;
            end
        end
    end

    task automatic cfg_xact(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] rd, output int lat);
        @(negedge clk);
        valid = 1'b1;
        addr  = a;
        wdata = d;
        wstrb = s;
        lat   = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ready && lat < 8);
        if (!ready) check_eq("cfg_timeout", {31'b0, ready}, 32'd1);
        rd    = rdata;
        valid = 1'b0;
        wstrb = '0;
    endtask

    task automatic cfg_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        int          lat;
        cfg_xact(a, d, s, rd, lat);
    endtask

    task automatic cfg_read(input logic [31:0] a, output logic [31:0] d);
        int lat;
        cfg_xact(a, 32'h0, 4'h0, d, lat);
    endtask

    task automatic wait_idle();
        logic [31:0] r;
        int          n;
        n = 0;
        do begin
            cfg_read(A_CTRL, r);
            n++;
        end while (r[0] && n < 500);
        check_eq("idle_reached", {31'b0, r[0]}, 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        int          lat;
        int          vc0;
        int          n;

        // Reset state
        @(negedge clk);
        check_eq("rst_m_valid", {31'b0, m_valid}, 32'd0);
        check_eq("rst_m_addr", m_addr, 32'd0);
        check_eq("rst_m_wdata", m_wdata, 32'd0);
        check_eq("rst_m_wstrb", {28'b0, m_wstrb}, 32'd0);
        check_eq("rst_ready", {31'b0, ready}, 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_irq", {31'b0, irq}, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        cfg_xact(A_CTRL, 32'h0, 4'h0, r, lat);
        check_eq("cfg_latency", 32'(lat), 32'd1);
        check_eq("rst_ctrl", r, 32'h0);
        @(negedge clk);
        check_eq("ready_one_cycle", {31'b0, ready}, 32'd0);
        cfg_read(A_LEN, r);
        check_eq("rst_len", r, 32'h0);

        // Byte strobes and alignment / width truncation
        cfg_write(A_SRC, 32'hAABBCCDF, 4'b0101);
        cfg_read(A_SRC, r);
        check_eq("src_strobe", r, 32'h00BB00DC);
        cfg_write(A_LEN, 32'h12345678, 4'hF);
        cfg_read(A_LEN, r);
        check_eq("len_trunc", r, 32'h00005678);

        // Basic 3-word copy, zero-latency memory
        for (int i = 0; i < 3; i++) mem[32'h100 + 32'(4 * i)] = 32'hC0DE_0000 + 32'(i);
        max_stall = 0;
        cfg_write(A_SRC, 32'h100, 4'hF);
        cfg_write(A_DST, 32'h200, 4'hF);
        cfg_write(A_LEN, 32'd3, 4'hF);
        push_copy(32'h100, 32'h200, 3);
        cfg_write(A_CTRL, 32'h5, 4'hF);
        wait_idle();
        check_eq("copy_q_empty", 32'(exp_q.size()), 32'd0);
        check_eq("copy_irq", {31'b0, irq}, 32'd1);
        cfg_read(A_CTRL, r);
        check_eq("copy_ctrl", r, 32'h6);
        cfg_read(A_LEN, r);
        check_eq("copy_len", r, 32'h0);
        cfg_read(A_SRC, r);
        check_eq("copy_src_end", r, 32'h10C);
        for (int i = 0; i < 3; i++)
            check_eq("copy_data", mem_rd(32'h200 + 32'(4 * i)), 32'hC0DE_0000 + 32'(i));

        // Zero-length transfer
        cfg_write(A_CTRL, 32'h2, 4'hF);
        cfg_write(A_LEN, 32'd0, 4'hF);
        vc0 = valid_cycles;
        cfg_write(A_CTRL, 32'h5, 4'hF);
        check_eq("len0_irq_early", {31'b0, irq}, 32'd0);
        @(negedge clk);
        check_eq("len0_done_2cyc", {31'b0, irq}, 32'd1);
        cfg_write(A_CTRL, 32'h2, 4'hF);
        cfg_write(A_CTRL, 32'h1, 4'hF);
        repeat (3) @(negedge clk);
        cfg_read(A_CTRL, r);
        check_eq("len0_ctrl", r, 32'h2);
        check_eq("len0_no_bus", 32'(valid_cycles), 32'(vc0));

        // Random stalls, plus writes while busy that must be ignored
        max_stall = 5;
        cfg_write(A_CTRL, 32'h2, 4'hF);
        cfg_write(A_SRC, 32'h400, 4'hF);
        cfg_write(A_DST, 32'h800, 4'hF);
        cfg_write(A_LEN, 32'd6, 4'hF);
        push_copy(32'h400, 32'h800, 6);
        cfg_write(A_CTRL, 32'h1, 4'hF);
        cfg_write(A_DST, 32'h300, 4'hF);
        cfg_write(A_CTRL, 32'h1, 4'hF);
        cfg_read(A_CTRL, r);
        check_eq("busy_mid", {31'b0, r[0]}, 32'd1);
        wait_idle();
        repeat (4) @(negedge clk);
        check_eq("stall_q_empty", 32'(exp_q.size()), 32'd0);
        cfg_read(A_DST, r);
        check_eq("busy_dst_kept", r, 32'h818);

        // Reset during a write
        cfg_write(A_CTRL, 32'h2, 4'hF);
        cfg_write(A_SRC, 32'h500, 4'hF);
        cfg_write(A_DST, 32'h600, 4'hF);
        cfg_write(A_LEN, 32'd4, 4'hF);
        push_copy(32'h500, 32'h600, 4);
        cfg_write(A_CTRL, 32'h5, 4'hF);
        n = 0;
        while (!(m_valid && m_wstrb == 4'hF) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("reach_wr", {31'b0, m_valid}, 32'd1);
        #1 resetn = 1'b0;
        #1;
        check_eq("arst_m_valid", {31'b0, m_valid}, 32'd0);
        check_eq("arst_m_addr", m_addr, 32'd0);
        check_eq("arst_m_wstrb", {28'b0, m_wstrb}, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        vc0 = valid_cycles;
        repeat (20) @(negedge clk);
        cfg_read(A_CTRL, r);
        check_eq("arst_ctrl", r, 32'h0);
        cfg_read(A_SRC, r);
        check_eq("arst_src", r, 32'h0);
        check_eq("arst_no_bus", 32'(valid_cycles), 32'(vc0));
        check_eq("arst_irq", {31'b0, irq}, 32'd0);

        // Source address wraps past 2^32
        max_stall = 0;
        cfg_write(A_SRC, 32'hFFFFFFFC, 4'hF);
        cfg_write(A_DST, 32'h1000, 4'hF);
        cfg_write(A_LEN, 32'd2, 4'hF);
        push_copy(32'hFFFFFFFC, 32'h1000, 2);
        cfg_write(A_CTRL, 32'h5, 4'hF);
        wait_idle();
        check_eq("wrap_q_empty", 32'(exp_q.size()), 32'd0);
        check_eq("wrap_data", mem_rd(32'h1004), 32'h0000_0000 ^ 32'h5a5a_1234);
        check_eq("wrap_irq", {31'b0, irq}, 32'd1);
        cfg_write(A_CTRL, 32'h2, 4'hF);
        @(negedge clk);
        check_eq("clr_irq", {31'b0, irq}, 32'd0);
        cfg_read(A_CTRL, r);
        check_eq("clr_ctrl", r, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/membus_dma.md
MEMBUS_DMA -- requirements
Module: membus_dma

Interface
REQ-001 SHALL have parameter LEN_BITS, default 16, width of the word-count register.
REQ-002 SHALL have port clk, input, 1, the only clock; all logic is rising-edge.
REQ-003 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have config responder ports: valid in 1, ready out 1, wstrb in 4, addr in 32, wdata in 32, rdata out 32.
REQ-005 SHALL have bus initiator ports: m_valid out 1, m_ready in 1, m_addr out 32, m_wdata out 32, m_wstrb out 4, m_rdata in 32.
REQ-006 SHALL have port irq, output, 1, level interrupt: done AND irq-enable.

Function
REQ-007 Config map, decoded on addr[3:2]: 0 SRC, 1 DST, 2 LEN (words, LEN_BITS), 3 CTRL. Reads: CTRL = {29'b0, ie, done, busy}.
REQ-008 Config ready SHALL assert exactly one cycle after valid rises and for one cycle only; rdata is valid in that cycle.
REQ-009 A config write SHALL update only the bytes selected by wstrb. SRC/DST bits [1:0] are forced to 0.
REQ-010 A CTRL write with wdata[0]=1 and wstrb[0]=1 SHALL start a transfer when idle, clear done, and take ie from wdata[2].
REQ-011 A CTRL write with wdata[1]=1 SHALL clear done (write-1-to-clear). Start and clear in the same write SHALL leave done=0.
REQ-012 While busy, writes to SRC, DST, LEN and start SHALL be ignored. ie SHALL remain writable.
REQ-013 The FSM SHALL have the states IDLE, RD, WR and FIN.
REQ-014 IDLE->RD on start with LEN!=0. IDLE->FIN on start with LEN==0.
REQ-015 In RD: m_valid=1, m_addr=current src, m_wstrb=0. On m_ready, latch m_rdata into the data buffer and go to WR.
REQ-016 In WR: m_valid=1, m_addr=current dst, m_wdata=buffer, m_wstrb=4'hF. On m_ready: src+=4, dst+=4, count-=1; go to RD if count!=0, else FIN.
REQ-017 Once asserted, m_valid and the m_addr/m_wdata/m_wstrb values SHALL be held stable until m_ready is sampled high.
REQ-018 m_valid SHALL drop in the cycle after m_ready. There is exactly one idle cycle between bus transactions.
REQ-019 FIN SHALL set done, clear busy, and return to IDLE after one cycle.
REQ-020 Address arithmetic SHALL be 32-bit and wrap modulo 2^32 without error.
REQ-021 The working SRC, DST and LEN registers SHALL update as the transfer runs. Reads during the transfer show progress; at completion LEN reads 0.
REQ-022 busy SHALL be 1 from the cycle after a start is accepted until FIN.
REQ-023 m_valid and ready SHALL be independent. The config port SHALL answer while a transfer is in flight.

Reset
REQ-024 Asserting resetn low SHALL force the following, asynchronously and mid-transfer included: FSM=IDLE; m_valid=0, m_wstrb=0, m_addr=0, m_wdata=0; ready=0, rdata=0.
REQ-025 Reset SHALL also clear SRC, DST, LEN, busy, done, ie, the data buffer, and irq.
REQ-026 An aborted bus transaction SHALL NOT be resumed after reset.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding and the register offset constants (REG_SRC=0, REG_DST=1, REG_LEN=2, REG_CTRL=3).
REQ-028 The block SHALL have one sub-module, membus_dma_regs: the config decode, byte-strobe write and read mux. The FSM/datapath stays in membus_dma.

Verification
REQ-029 Program SRC=0x100, DST=0x200, LEN=3, CTRL=0x5; memory model with 0-cycle m_ready -> 3 reads at 0x100/104/108 and 3 writes at 0x200/204/208 with copied data. Then done=1, irq=1, LEN reads 0.
REQ-030 LEN=0 with start -> no m_valid pulse; done=1 two cycles after start; CTRL reads 0x2 (ie=0).
REQ-031 Memory model with random 0-5 cycle m_ready stalls -> m_addr, m_wdata and m_wstrb stable throughout every stall, and data correct.
REQ-032 Write DST=0x300 and start while busy -> ignored; the transfer finishes to the original DST.
REQ-033 Deassert resetn during WR state -> m_valid=0 immediately; CTRL reads 0 after release; no further bus activity.
REQ-034 SRC=0xFFFFFFFC, LEN=2 -> second read at 0x00000000; CTRL write 0x2 -> done=0 and irq=0.
